// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   // Responder FSM states; also exported on the debug port.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEPTH_DEF = 64;   // words stored
   localparam int LAT_DEF   = 2;    // accept-to-response cycles (1..15)
   localparam int CNT_W     = 4;    // latency counter width

   // A request is in error when it is not word aligned or its word index
   // falls outside the array; upper address bits only matter through the
   // range test.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU MEM-stage to data-memory request/response bundle.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. The responder raises req_ready only when idle;
// req_valid seen while req_ready is 0 is ignored, never queued, so the CPU
// holds its request while mem_busy is 1. resp_valid is a one-cycle strobe
// with no back-pressure, and resp_rdata/resp_err are meaningful only with it.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_busy
   );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, waits LAT
// cycles, emits a one-cycle response, then returns to idle.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int LAT   = LAT_DEF
) (
   input  logic   Clock,
   input  logic   Resetn,
   dmem_responder_if.slave bus,
   output state_t state_dbg
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lat_we;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;

   logic             ready_q;
   logic             valid_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             busy_q;

   logic             accept;
   logic             go_resp;
   logic             sel_we;
   logic [31:0]      sel_addr;
   logic [31:0]      sel_wdata;
   logic             sel_err;
   logic [IDX_W-1:0] sel_idx;
   logic             arr_we;
   logic [31:0]      arr_rdata;
   logic [31:0]      resp_data;

   assign accept = bus.req_valid & ready_q;

   // Edge that enters RESP: straight from IDLE when LAT is 1, else the
   // WAIT cycle whose counter reads 0.
   assign go_resp = ((state == IDLE) && accept && (LAT == 1)) ||
                    ((state == WAIT) && (cnt == '0));

   // With LAT=1 the request is still on the bus at the RESP-entry edge, so
   // the array and error check look at the bus; otherwise at the latch.
   always_comb begin
      sel_we    = lat_we;
      sel_addr  = lat_addr;
      sel_wdata = lat_wdata;
      if (state == IDLE) begin
         sel_we    = bus.req_we;
         sel_addr  = bus.req_addr;
         sel_wdata = bus.req_wdata;
      end
   end

   assign sel_err   = addr_err(sel_addr, DEPTH);
   assign sel_idx   = sel_addr[IDX_W+1:2];
   // Resetn gating keeps an aborted store from landing in the array.
   assign arr_we    = go_resp & sel_we & ~sel_err & Resetn;
   assign resp_data = (sel_we | sel_err) ? 32'd0 : arr_rdata;

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (Clock),
      .we    (arr_we),
      .addr  (sel_idx),
      .wdata (sel_wdata),
      .rdata (arr_rdata)
   );

   // Request FSM with latency counter, request latch and registered outputs.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we    <= bus.req_we;
                  lat_addr  <= bus.req_addr;
                  lat_wdata <= bus.req_wdata;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  if (LAT == 1) begin
                     state   <= RESP;
                     valid_q <= 1'b1;
                     err_q   <= sel_err;
                     rdata_q <= resp_data;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(LAT - 2);
                  end
               end
            end
            WAIT: begin
               if (go_resp) begin
                  state   <= RESP;
                  valid_q <= 1'b1;
                  err_q   <= sel_err;
                  rdata_q <= resp_data;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.mem_busy   = busy_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LAT=2 and one LAT=1 instance.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int W = 34;  // {check_rdata, err, rdata}

   logic   Clock = 1'b0;
   logic   Resetn;
   state_t st2, st1;

   dmem_responder_if b2();
   dmem_responder_if b1();

   int checks = 0;
   int errors = 0;
   int acc2 = 0, rsp2 = 0, acc1 = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] sb_e;

   logic [31:0] wd1 [4];

   dmem_responder #(.DEPTH(64), .LAT(2)) u_lat2 (
      .Clock(Clock), .Resetn(Resetn), .bus(b2), .state_dbg(st2)
   );

   dmem_responder #(.DEPTH(64), .LAT(1)) u_lat1 (
      .Clock(Clock), .Resetn(Resetn), .bus(b1), .state_dbg(st1)
   );

   // Clock / watchdog
   always #5 Clock = ~Clock;

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Accept counters
   always @(posedge Clock) begin
      if (Resetn === 1'b1 && b2.req_valid === 1'b1 && b2.req_ready === 1'b1) acc2++;
      if (Resetn === 1'b1 && b1.req_valid === 1'b1 && b1.req_ready === 1'b1) acc1++;
   end

   // Scoreboard for the LAT=2 instance
   always @(negedge Clock) begin
      if (b2.resp_valid === 1'b1) begin
         rsp2++;
         if (exp_q.size() == 0) begin
            check("sb_unexpected_resp", 32'd1, 32'd0);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_err", 32'(b2.resp_err), 32'(sb_e[32]));
            if (sb_e[33]) check("sb_rdata", b2.resp_rdata, sb_e[31:0]);
         end
      end
   end

   // Driver: one request on the LAT=2 instance with timing checks
   task automatic req2(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata);
      int waited = 0;
      @(negedge Clock);
      while (b2.req_ready !== 1'b1 && waited < 20) begin
         @(negedge Clock);
         waited++;
      end
      check("req2_ready", 32'(b2.req_ready), 32'd1);
      if (b2.req_ready !== 1'b1) return;
      b2.req_valid = 1'b1;
      b2.req_we    = we;
      b2.req_addr  = addr;
      b2.req_wdata = wdata;
      exp_q.push_back({~we, exp_err, exp_rdata});
      @(posedge Clock);
      #1 b2.req_valid = 1'b0;
      @(negedge Clock);
      check("req2_wait_novalid", 32'(b2.resp_valid), 32'd0);
      check("req2_wait_state", 32'(st2), 32'(WAIT));
      @(negedge Clock);
      check("req2_resp_at_lat", 32'(b2.resp_valid), 32'd1);
      check("req2_resp_noready", 32'(b2.req_ready), 32'd0);
      @(negedge Clock);
      check("req2_post_valid", 32'(b2.resp_valid), 32'd0);
      check("req2_post_ready", 32'(b2.req_ready), 32'd1);
      check("req2_post_rdata", b2.resp_rdata, 32'd0);
      check("req2_post_err", 32'(b2.resp_err), 32'd0);
   endtask

   // Driver: one store on the LAT=1 instance
   task automatic store1(input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge Clock);
      check("s1_ready", 32'(b1.req_ready), 32'd1);
      b1.req_valid = 1'b1;
      b1.req_we    = 1'b1;
      b1.req_addr  = addr;
      b1.req_wdata = wdata;
      @(posedge Clock);
      #1 b1.req_valid = 1'b0;
      @(negedge Clock);
      check("s1_resp", 32'(b1.resp_valid), 32'd1);
      check("s1_err", 32'(b1.resp_err), 32'd0);
   endtask

   // Main sequence
   initial begin
      int a0, r0, a1;
      wd1[0] = 32'h0102_0304;
      wd1[1] = 32'hA5A5_5A5A;
      wd1[2] = 32'hFFFF_0000;
      wd1[3] = 32'h0000_FFFF;
      b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
      b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;

      // Reset
      Resetn = 1'b0;
      repeat (3) @(posedge Clock);
      #1 Resetn = 1'b1;
      @(negedge Clock);
      check("rst_ready2", 32'(b2.req_ready), 32'd1);
      check("rst_valid2", 32'(b2.resp_valid), 32'd0);
      check("rst_rdata2", b2.resp_rdata, 32'd0);
      check("rst_err2", 32'(b2.resp_err), 32'd0);
      check("rst_busy2", 32'(b2.mem_busy), 32'd0);
      check("rst_state2", 32'(st2), 32'(IDLE));
      check("rst_ready1", 32'(b1.req_ready), 32'd1);
      check("rst_busy1", 32'(b1.mem_busy), 32'd0);

      // Store then load the same word
      req2(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
      req2(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);

      // Misaligned store must not touch word 4
      req2(1'b1, 32'h13, 32'hCAFEF00D, 1'b1, 32'd0);
      req2(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);

      // Range errors, including an aliasing store that must not write word 0
      req2(1'b0, 32'h100, 32'd0, 1'b1, 32'd0);
      req2(1'b1, 32'h0, 32'h11111111, 1'b0, 32'd0);
      req2(1'b1, 32'h100, 32'h99999999, 1'b1, 32'd0);
      req2(1'b0, 32'h0, 32'd0, 1'b0, 32'h11111111);
      req2(1'b0, 32'h8000_0010, 32'd0, 1'b1, 32'd0);
      req2(1'b0, 32'h2, 32'd0, 1'b1, 32'd0);

      // Last word in range
      req2(1'b1, 32'hFC, 32'h0000_003F, 1'b0, 32'd0);
      req2(1'b0, 32'hFC, 32'd0, 1'b0, 32'h0000_003F);

      // Reset during WAIT aborts a store
      req2(1'b1, 32'h20, 32'hAAAA5555, 1'b0, 32'd0);
      @(negedge Clock);
      b2.req_valid = 1'b1; b2.req_we = 1'b1;
      b2.req_addr = 32'h20; b2.req_wdata = 32'h12345678;
      @(posedge Clock);
      #1 b2.req_valid = 1'b0;
      @(negedge Clock);
      check("abort_in_wait", 32'(st2), 32'(WAIT));
      Resetn = 1'b0;
      @(posedge Clock);
      #1 Resetn = 1'b1;
      @(negedge Clock);
      check("abort_ready", 32'(b2.req_ready), 32'd1);
      check("abort_busy", 32'(b2.mem_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("abort_no_resp", 32'(b2.resp_valid), 32'd0);
         @(negedge Clock);
      end
      req2(1'b0, 32'h20, 32'd0, 1'b0, 32'hAAAA5555);

      // req_valid toggled while busy: exactly one accept and one response
      a0 = acc2;
      r0 = rsp2;
      @(negedge Clock);
      b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_addr = 32'h10;
      exp_q.push_back({1'b1, 1'b0, 32'hDEADBEEF});
      @(posedge Clock);
      for (int k = 0; k < 10; k++) begin
         @(negedge Clock);
         if (b2.mem_busy !== 1'b1) begin
            b2.req_valid = 1'b0;
            break;
         end
         b2.req_valid = ~b2.req_valid;
         b2.req_addr  = 32'h40 + 32'(4 * k);
      end
      repeat (4) @(negedge Clock);
      check("toggle_accepts", 32'(acc2 - a0), 32'd1);
      check("toggle_resps", 32'(rsp2 - r0), 32'd1);

      // LAT=1 back-to-back loads with req_valid held
      for (int i = 0; i < 4; i++) store1(32'(4 * i), wd1[i]);
      a1 = acc1;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clock);
         b1.req_valid = 1'b1;
         b1.req_we    = 1'b0;
         b1.req_addr  = 32'(4 * (k / 2));
         check("l1_exclusive", 32'(b1.req_ready & b1.resp_valid), 32'd0);
         if (k % 2 == 0) begin
            check("l1_ready", 32'(b1.req_ready), 32'd1);
            check("l1_idle_novalid", 32'(b1.resp_valid), 32'd0);
         end else begin
            check("l1_resp", 32'(b1.resp_valid), 32'd1);
            check("l1_rdata", b1.resp_rdata, wd1[k / 2]);
            check("l1_err", 32'(b1.resp_err), 32'd0);
         end
      end
      @(negedge Clock);
      b1.req_valid = 1'b0;
      check("l1_accepts", 32'(acc1 - a1), 32'd4);

      // Report
      repeat (2) @(negedge Clock);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter LAT, default 2, range 1..15, meaning the cycles from request accept to response.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Resetn, input, 1 bit: reset is synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the CPU MEM stage presents a request.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port req_wdata, input, 32 bits: store data.
REQ-009 The block SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a one-cycle response strobe.
REQ-011 The block SHALL have port resp_rdata, output, 32 bits: load data, valid with resp_valid.
REQ-012 The block SHALL have port resp_err, output, 1 bit: the request was misaligned or out of range, valid with resp_valid.
REQ-013 The block SHALL have port mem_busy, output, 1 bit: the pipeline stall source, high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states:
  - IDLE: req_ready=1.
  - WAIT: latency countdown.
  - RESP: resp_valid=1 for exactly one cycle.
REQ-015 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; the block SHALL latch we, addr and wdata at that edge.
REQ-016 On accept, the FSM SHALL go to RESP if LAT=1; otherwise it SHALL go to WAIT and load a 4-bit counter with LAT-2.
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP in the cycle after the counter reads 0.
REQ-018 resp_valid SHALL be high exactly LAT cycles after the accept edge; req_ready and resp_valid SHALL never be high together.
REQ-019 From RESP the FSM SHALL always return to IDLE, giving a maximum throughput of one request per LAT+1 cycles.
REQ-020 The error condition SHALL be latched addr[1:0]!=0 or addr[31:2]>=DEPTH; resp_err SHALL equal that condition during RESP.
REQ-021 A store without error SHALL write word addr[31:2] at the RESP-entry edge; an errored store SHALL write nothing.
REQ-022 A load without error SHALL drive resp_rdata with the array word in RESP; an errored load SHALL drive 0.
REQ-023 A load following a store to the same word SHALL return the stored data.
REQ-024 Outside RESP, resp_rdata and resp_err SHALL be 0.
REQ-025 req_valid asserted outside IDLE SHALL be ignored and not queued; the CPU holds the request while mem_busy=1.
REQ-026 Address arithmetic SHALL be unsigned; bits above the index width SHALL be checked only through the range test.

Reset
REQ-027 While Resetn=0 at a rising edge, the block SHALL set state=IDLE, counter=0 and all latched request fields=0.
REQ-028 After reset, the outputs SHALL be req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_busy=0.
REQ-029 A reset arriving in WAIT or RESP SHALL abort the request without a response, and a pending store SHALL not be written.
REQ-030 Array contents SHALL be unaffected by reset.

Structure
REQ-031 A shared package dmem_pkg SHALL hold the state type (IDLE/WAIT/RESP), the DEPTH and LAT defaults, and the counter width constant.
REQ-032 The storage SHALL be one sub-module, dmem_array: a single-port word RAM with synchronous write and combinational read, indexed by addr[31:2].
REQ-033 The FSM, counter, request latch and error check SHALL live in dmem_responder.

Verification
REQ-034 The bench SHALL run LAT=2: store addr 0x10 data 0xDEADBEEF -> resp_valid at accept+2, resp_err=0; then load 0x10 -> resp_rdata=0xDEADBEEF at accept+2.
REQ-035 The bench SHALL run LAT=1 back-to-back loads with req_valid held -> accepts every 2 cycles, resp_valid never coincides with req_ready.
REQ-036 The bench SHALL store to addr 0x13 (misaligned) -> resp_err=1, resp_rdata=0, and word 4 unchanged on readback.
REQ-037 The bench SHALL load addr 0x100 with DEPTH=64 -> resp_err=1, resp_rdata=0.
REQ-038 The bench SHALL pulse Resetn=0 in WAIT of a store to 0x20 data 0x12345678 -> no resp_valid, req_ready=1 after reset, and a load of 0x20 returns the prior value.
REQ-039 The bench SHALL toggle req_valid while mem_busy=1 -> no extra accepts, and the response count equals the accept count.
